// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event payload for the PS/2 scancode decoder.
package ps2_pkg;

  localparam int unsigned CODE_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EVT_W  = 10;

  localparam logic [BYTE_W-1:0] BYTE_00 = 8'h00;
  localparam logic [BYTE_W-1:0] PFX_E0  = 8'hE0;
  localparam logic [BYTE_W-1:0] PFX_F0  = 8'hF0;
  localparam logic [BYTE_W-1:0] PFX_E1  = 8'hE1;
  localparam logic [BYTE_W-1:0] PFX_FF  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STABLE = 2'd1,
    ST_PUSH   = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic              ext;
    logic              brk;
    logic [BYTE_W-1:0] code;
  } ps2_evt_t;

  // Low byte decides whether the word carries a real key code.
  function automatic logic is_decodable(input logic [BYTE_W-1:0] lo);
    return !(lo inside {BYTE_00, PFX_E0, PFX_F0, PFX_E1, PFX_FF});
  endfunction

  function automatic ps2_evt_t classify(input logic [CODE_W-1:0] w);
    ps2_evt_t e;
    e.code = w[BYTE_W-1:0];
    e.ext  = (w[CODE_W-1:BYTE_W] == PFX_E0);
    e.brk  = (w[CODE_W-1:BYTE_W] == PFX_F0);
    return e;
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Event stream from the decoder to its consumer (valid/ready handshake).
interface ps2_scancode_decoder_if;
  import ps2_pkg::*;

  logic              evt_valid;
  logic              evt_ready;
  logic [BYTE_W-1:0] evt_code;
  logic              evt_ext;
  logic              evt_brk;

  modport master (output evt_valid, evt_code, evt_ext, evt_brk, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_ext, evt_brk, output evt_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Small power-of-two event FIFO; a full push is accepted only alongside a pop.
module ps2_evt_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 10,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty_c;
  assign push_ok = push && (!full_c || pop_ok);
  // Head is masked to zero when empty so no stale entry leaks out.
  assign rdata_c = empty_c ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Debounces the receiver's scancode word, classifies make/break/extended keys
// and queues one event per distinct stable key code.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CODE_W-1:0]             code,
  input  logic                          ovf_clr,
  ps2_scancode_decoder_if.master        evt,
  output logic [4:0]                    evt_count,
  output logic                          overflow
);

  localparam int unsigned CNT_W     = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam int unsigned FCNT_W    = $clog2(FIFO_DEPTH + 1);

  ps2_state_e          state_q, state_d;
  logic [CODE_W-1:0]   last_code;
  logic [CODE_W-1:0]   cap_q, cap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                push_c;
  logic                pop_c;
  logic                drop_c;
  logic                change_c;
  logic                dec_c;
  logic                full_c;
  logic                empty_c;
  logic [FCNT_W-1:0]   fifo_count;
  logic [EVT_W-1:0]    head_raw;
  ps2_evt_t            head;
  ps2_evt_t            push_evt;

  assign change_c = (code != last_code);
  assign dec_c    = is_decodable(code[BYTE_W-1:0]);
  assign push_evt = classify(cap_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cap_q     <= '0;
      cnt_q     <= '0;
      last_code <= '0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      cnt_q     <= cnt_d;
      last_code <= code;
    end
  end

  // Next state: a decodable word must hold unchanged before it is queued once.
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    push_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (change_c && dec_c) begin
          state_d = ST_STABLE;
          cap_d   = code;
          cnt_d   = '0;
        end
      end
      ST_STABLE: begin
        if (code == cap_q) begin
          if (cnt_q == CNT_LAST) state_d = ST_PUSH;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end else if (dec_c) begin
          cap_d = code;
          cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUSH: begin
        push_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop_c  = evt.evt_valid && evt.evt_ready;
  assign drop_c = push_c && full_c && !pop_c;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .wdata   (push_evt),
    .pop     (pop_c),
    .rdata_c (head_raw),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (fifo_count)
  );

  assign head          = ps2_evt_t'(head_raw);
  assign evt.evt_valid = !empty_c;
  assign evt.evt_code  = head.code;
  assign evt.evt_ext   = head.ext;
  assign evt.evt_brk   = head.brk;
  assign evt_count     = 5'(fifo_count);

  // A dropping push wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop_c)  overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a history-based reference model.
module tb_ps2_scancode_decoder;

  localparam int S = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] code = 16'h0000;
  logic        ovf_clr = 1'b0;
  logic        ready = 1'b1;
  logic [4:0]  evt_count;
  logic        overflow;

  ps2_scancode_decoder_if evt_bus();
  assign evt_bus.evt_ready = ready;

  ps2_scancode_decoder #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code      (code),
    .ovf_clr   (ovf_clr),
    .evt       (evt_bus),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: event decided from the sample history of code.
  logic [15:0] ch [S+1];
  bit          cap [S+1];
  logic [9:0]  mq [$];
  bit          m_ovf;
  bit          rdy_edge;

  function automatic bit decodable(input logic [15:0] w);
    logic [7:0] lo;
    lo = w[7:0];
    return !(lo == 8'h00 || lo == 8'hE0 || lo == 8'hF0 || lo == 8'hE1 || lo == 8'hFF);
  endfunction

  function automatic logic [9:0] entry(input logic [15:0] w);
    if (w[15:8] == 8'hF0) return {2'b01, w[7:0]};
    if (w[15:8] == 8'hE0) return {2'b10, w[7:0]};
    return {2'b00, w[7:0]};
  endfunction

  always @(posedge clk) begin : model
    bit push, pop, drop, capn;
    rdy_edge = ready;
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) begin ch[k] = 16'h0; cap[k] = 1'b0; end
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      push = cap[S];
      for (int k = 0; k < S; k++) if (ch[k] != ch[S]) push = 1'b0;
      capn = decodable(code) && (code != ch[0]) && !push;
      pop  = (mq.size() > 0) && ready;
      drop = push && (mq.size() == D) && !pop;
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(entry(ch[S]));
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      for (int k = S; k > 0; k--) begin ch[k] = ch[k-1]; cap[k] = cap[k-1]; end
      ch[0]  = code;
      cap[0] = capn;
    end
  end

  // Per-cycle compare plus a log of events the DUT actually handed over.
  logic [9:0] popped [$];
  bit         prev_valid = 1'b0;
  logic [9:0] prev_head = 10'h0;

  always @(posedge clk) begin : compare
    logic [17:0] act, exp;
    logic [9:0]  eh;
    #1;
    eh  = (mq.size() > 0) ? mq[0] : 10'h0;
    exp = {(mq.size() > 0), eh, 5'(mq.size()), m_ovf};
    act = {evt_bus.evt_valid, evt_bus.evt_ext, evt_bus.evt_brk, evt_bus.evt_code,
           evt_count, overflow};
    check("cycle", 32'(act), 32'(exp));
    if (rst_n && prev_valid && rdy_edge) popped.push_back(prev_head);
    prev_valid = rst_n && evt_bus.evt_valid;
    prev_head  = {evt_bus.evt_ext, evt_bus.evt_brk, evt_bus.evt_code};
  end

  task automatic hold(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      code = w;
    end
  endtask

  task automatic check_popped(input string nm, input int n,
                              input logic [9:0] e0, input logic [9:0] e1,
                              input logic [9:0] e2, input logic [9:0] e3,
                              input logic [9:0] e4);
    logic [9:0] e [5];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    check({nm, "_n"}, 32'(popped.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < popped.size()) check({nm, "_evt"}, 32'(popped[i]), 32'(e[i]));
  endtask

  initial begin
    int rise, high;
    logic [9:0] got;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(evt_bus.evt_valid), 32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    hold(16'h0000, 3);

    // Single make code: latency and one-cycle valid with ready high
    @(negedge clk);
    code = 16'h001C;
    rise = -1; high = 0; got = 10'h0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (evt_bus.evt_valid) begin
        if (rise < 0) begin
          rise = i;
          got  = {evt_bus.evt_ext, evt_bus.evt_brk, evt_bus.evt_code};
        end
        high++;
      end
    end
    check("lat_rise", 32'(rise), 32'd6);
    check("lat_high", 32'(high), 32'd1);
    check("lat_evt", 32'(got), 32'h01C);

    // Break, extended, and ignored prefix/idle words
    popped.delete();
    hold(16'hF01C, 10);
    hold(16'hE075, 10);
    hold(16'h00E0, 10);
    hold(16'h00F0, 10);
    hold(16'h00FF, 10);
    hold(16'h0000, 3);
    check_popped("classify", 2, 10'h11C, 10'h275, 10'h0, 10'h0, 10'h0);

    // Short runs are discarded; a recapture yields a single event
    popped.delete();
    hold(16'h001C, 2);
    hold(16'h0000, 3);
    hold(16'h001C, 2);
    hold(16'h0032, 10);
    check_popped("bounce", 1, 10'h032, 10'h0, 10'h0, 10'h0, 10'h0);

    // Overflow with five keys and no consumer
    @(negedge clk); ready = 1'b0;
    popped.delete();
    hold(16'h001C, 8);
    hold(16'h0032, 8);
    hold(16'h0021, 8);
    hold(16'h0023, 8);
    hold(16'h0024, 8);
    check("ovf_count", 32'(evt_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    @(negedge clk); ready = 1'b1;
    repeat (4) @(negedge clk);
    ready = 1'b0;
    check_popped("ovf_order", 4, 10'h01C, 10'h032, 10'h021, 10'h023, 10'h0);
    check("drained", 32'(evt_count), 32'd0);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Push into a full FIFO in the same cycle as a pop
    popped.delete();
    hold(16'h001C, 8);
    hold(16'h0032, 8);
    hold(16'h0021, 8);
    hold(16'h0023, 8);
    check("full_count", 32'(evt_count), 32'd4);
    @(negedge clk); code = 16'h0044;
    repeat (5) @(negedge clk);
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    check("pp_count", 32'(evt_count), 32'd4);
    check("pp_ovf", 32'(overflow), 32'd0);

    // Dropping push coinciding with a clear keeps overflow set
    @(negedge clk); code = 16'h0045;
    repeat (5) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("ovf_vs_clr", 32'(overflow), 32'd1);
    @(negedge clk); ready = 1'b1;
    repeat (6) @(negedge clk);
    ready = 1'b0;
    check_popped("pp_order", 5, 10'h01C, 10'h032, 10'h021, 10'h023, 10'h044);

    // Reset with events queued and a capture in flight
    hold(16'h0051, 8);
    hold(16'h0052, 8);
    hold(16'h0053, 8);
    check("pre_rst_count", 32'(evt_count), 32'd3);
    @(negedge clk); code = 16'h0055;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    code  = 16'h0000;
    @(negedge clk);
    check("mid_rst_out", 32'({evt_bus.evt_valid, evt_bus.evt_ext, evt_bus.evt_brk,
                              evt_bus.evt_code, evt_count, overflow}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    hold(16'h0000, 12);
    check("post_rst_count", 32'(evt_count), 32'd0);
    check("post_rst_valid", 32'(evt_bus.evt_valid), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive clk cycles a candidate code must hold before it is accepted (legal range 1..15).
REQ-002 Parameter: FIFO_DEPTH, default 4, number of event entries buffered (power of two, 2..16).
REQ-003 Port: clk  input  1  system clock; every register is clocked on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: code  input  16  last-two-bytes scancode word from the upstream PS/2 receiver, synchronous to clk.
REQ-006 Port: evt_ready  input  1  consumer accepts the head event this cycle.
REQ-007 Port: ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-008 Port: evt_valid  output  1  head event present (FIFO not empty).
REQ-009 Port: evt_code  output  8  key scancode byte of the head event.
REQ-010 Port: evt_ext  output  1  head event is an extended (E0-prefixed) key.
REQ-011 Port: evt_brk  output  1  head event is a break (key release).
REQ-012 Port: evt_count  output  5  number of events held, 0..FIFO_DEPTH.
REQ-013 Port: overflow  output  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-014 A decodable word SHALL have a low byte outside {00, E0, F0, E1, FF}; every other word is treated as idle/prefix/error and ignored.
REQ-015 Classification SHALL be: high byte F0 -> brk=1, ext=0; high byte E0 -> ext=1, brk=0; any other high byte -> ext=0, brk=0; evt_code = low byte in all cases.
REQ-016 A register last_code SHALL capture code every cycle; a change is code != last_code.
REQ-017 FSM states: IDLE, STABLE, PUSH.
REQ-018 IDLE: on a change to a decodable word -> STABLE, capturing the word and clearing the stability counter.
REQ-019 STABLE: code equal to the captured word increments the counter; when counter reaches STABLE_CYCLES-1 -> PUSH.
REQ-020 STABLE: a different decodable word recaptures it and restarts the counter; a non-decodable word -> IDLE with no event.
REQ-021 PUSH: the event is written to the FIFO in this cycle; next state is IDLE unconditionally.
REQ-022 An unchanged word (same key code held) SHALL produce exactly one event; the same key re-triggers only after code passes through a different value.
REQ-023 Latency: from the first cycle a new decodable word is on code with no intervening change, evt_valid (FIFO previously empty) SHALL rise STABLE_CYCLES+2 cycles later.
REQ-024 FIFO SHALL be first-in first-out; a pop occurs when evt_valid && evt_ready; evt_code/ext/brk SHALL show the head entry and remain stable while evt_valid && !evt_ready.
REQ-025 Push and pop in the same cycle SHALL both take effect, including when full (count unchanged) and when empty with valid=0 (push only).
REQ-026 A push when full with no same-cycle pop SHALL drop the new event, leave contents unchanged, and set overflow.
REQ-027 overflow SHALL stay 1 until ovf_clr=1; if ovf_clr and a dropping push coincide, overflow SHALL remain 1.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-029 While rst_n=0: FSM=IDLE, counter=0, last_code=0000, pointers=0, evt_count=0, evt_valid=0, evt_code=00, evt_ext=0, evt_brk=0, overflow=0.
REQ-030 Reset asserted mid-STABLE or mid-PUSH SHALL discard the pending event and all buffered events.

Structure
REQ-031 Shared package ps2_pkg SHALL hold prefix constants (E0, F0, E1, FF), FSM state encodings, and the event-entry width (10 bits: ext, brk, code).
REQ-032 The buffer SHALL be a sub-module ps2_evt_fifo (parameterised depth/width, push/pop, full/empty/count); the FSM and classifier live in the top.

Verification
REQ-033 code 0000 -> 001C held 10 cycles, evt_ready=1 -> one event code=1C ext=0 brk=0, evt_valid high exactly 1 cycle, 6 cycles after first 001C sample.
REQ-034 code F01C held -> brk=1 code=1C; code E075 -> ext=1 code=75; code 00E0, 00F0, 00FF held -> no event.
REQ-035 code 001C for 2 cycles, then 0000 -> no event; 001C for 2 cycles, then 0032 held -> single event code=32.
REQ-036 evt_ready=0, five distinct keys 1C,32,21,23,24 -> evt_count=4, overflow=1, pop order 1C,32,21,23; ovf_clr -> overflow=0.
REQ-037 FIFO full, new event pushed in same cycle as pop -> count stays 4, new entry appears last.
REQ-038 rst_n pulsed low with 3 events queued and FSM in STABLE -> all outputs at reset values, no event after release.
